// File: rtl/ram_arbiter.sv
// Round-robin arbiter sequencing a single-port fixed-latency RAM between the CPU MAR/MDR path and a DMA port.
// Define RAM_ARB_CPU_PRIORITY_EN to make the CPU win every tie.
module ram_arbiter #(
  parameter int unsigned ADDR_W  = 9,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MEM_LAT = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_done,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_done,
  output logic              ram_read,
  output logic              ram_write,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy,
  output logic              grant_dma
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MEM_LAT - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  logic [1:0]        r_state,     w_state_nxt;
  logic [CNT_W-1:0]  r_cnt,       w_cnt_nxt;
  logic              r_read,      w_read_nxt;
  logic              r_write,     w_write_nxt;
  logic [ADDR_W-1:0] r_addr,      w_addr_nxt;
  logic [DATA_W-1:0] r_wdata,     w_wdata_nxt;
  logic [DATA_W-1:0] r_cpu_rdata, w_cpu_rdata_nxt;
  logic [DATA_W-1:0] r_dma_rdata, w_dma_rdata_nxt;
  logic              r_cpu_done,  w_cpu_done_nxt;
  logic              r_dma_done,  w_dma_done_nxt;
  logic              r_busy,      w_busy_nxt;
  logic              r_grant_dma, w_grant_dma_nxt;
  logic              r_last_dma,  w_last_dma_nxt;
  logic              w_pick_dma;

  // Tie-break: DMA only when the CPU is idle, or (round-robin) when the CPU was served last.
  always_comb begin
`ifdef RAM_ARB_CPU_PRIORITY_EN
    w_pick_dma = dma_req & ~cpu_req;
`else
    w_pick_dma = dma_req & (~cpu_req | ~r_last_dma);
`endif
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_read_nxt      = r_read;
    w_write_nxt     = r_write;
    w_addr_nxt      = r_addr;
    w_wdata_nxt     = r_wdata;
    w_cpu_rdata_nxt = r_cpu_rdata;
    w_dma_rdata_nxt = r_dma_rdata;
    w_cpu_done_nxt  = 1'b0;
    w_dma_done_nxt  = 1'b0;
    w_busy_nxt      = r_busy;
    w_grant_dma_nxt = r_grant_dma;
    w_last_dma_nxt  = r_last_dma;
    case (r_state)
      S_IDLE: begin
        if (cpu_req || dma_req) begin
          w_grant_dma_nxt = w_pick_dma;
          w_addr_nxt      = w_pick_dma ? dma_addr  : cpu_addr;
          w_wdata_nxt     = w_pick_dma ? dma_wdata : cpu_wdata;
          w_write_nxt     = w_pick_dma ? dma_we    : cpu_we;
          w_read_nxt      = ~(w_pick_dma ? dma_we  : cpu_we);
          w_busy_nxt      = 1'b1;
          w_cnt_nxt       = '0;
          w_state_nxt     = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (r_cnt == LAST_CNT) begin
          if (r_read) begin
            if (r_grant_dma) w_dma_rdata_nxt = ram_rdata;
            else             w_cpu_rdata_nxt = ram_rdata;
          end
          w_read_nxt     = 1'b0;
          w_write_nxt    = 1'b0;
          w_busy_nxt     = 1'b0;
          w_cpu_done_nxt = ~r_grant_dma;
          w_dma_done_nxt = r_grant_dma;
          w_last_dma_nxt = r_grant_dma;
          w_state_nxt    = S_DONE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_read      <= 1'b0;
      r_write     <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_cpu_rdata <= '0;
      r_dma_rdata <= '0;
      r_cpu_done  <= 1'b0;
      r_dma_done  <= 1'b0;
      r_busy      <= 1'b0;
      r_grant_dma <= 1'b0;
      r_last_dma  <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_read      <= w_read_nxt;
      r_write     <= w_write_nxt;
      r_addr      <= w_addr_nxt;
      r_wdata     <= w_wdata_nxt;
      r_cpu_rdata <= w_cpu_rdata_nxt;
      r_dma_rdata <= w_dma_rdata_nxt;
      r_cpu_done  <= w_cpu_done_nxt;
      r_dma_done  <= w_dma_done_nxt;
      r_busy      <= w_busy_nxt;
      r_grant_dma <= w_grant_dma_nxt;
      r_last_dma  <= w_last_dma_nxt;
    end
  end

  assign ram_read  = r_read;
  assign ram_write = r_write;
  assign ram_addr  = r_addr;
  assign ram_wdata = r_wdata;
  assign cpu_rdata = r_cpu_rdata;
  assign dma_rdata = r_dma_rdata;
  assign cpu_done  = r_cpu_done;
  assign dma_done  = r_dma_done;
  assign busy      = r_busy;
  assign grant_dma = r_grant_dma;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter (MEM_LAT=2) with a behavioural RAM; honours RAM_ARB_CPU_PRIORITY_EN.
module tb_ram_arbiter;

  localparam int unsigned ADDR_W  = 9;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned MEM_LAT = 2;

  logic              clock = 1'b0;
  logic              reset;
  logic              cpu_req, cpu_we, dma_req, dma_we;
  logic [ADDR_W-1:0] cpu_addr, dma_addr, ram_addr;
  logic [DATA_W-1:0] cpu_wdata, dma_wdata, cpu_rdata, dma_rdata, ram_wdata, ram_rdata;
  logic              cpu_done, dma_done, ram_read, ram_write, busy, grant_dma;

  logic [DATA_W-1:0] mem [512];
  int n_vec  = 0;
  int n_miss = 0;

  ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT)) dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_done(cpu_done),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata), .dma_done(dma_done),
    .ram_read(ram_read), .ram_write(ram_write), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .busy(busy), .grant_dma(grant_dma)
  );

  always #5 clock = ~clock;

  assign ram_rdata = mem[ram_addr];
  always @(posedge clock) if (ram_write) mem[ram_addr] <= ram_wdata;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Strobes must be mutually exclusive on every cycle.
  always @(negedge clock) if (reset) chk("strobe_excl", 64'(ram_read & ram_write), 64'd0);

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Bounded wait for the next completion pulse; reports which port finished.
  task automatic wait_done(output logic got_cpu, output logic got_dma);
    got_cpu = 1'b0;
    got_dma = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (cpu_done || dma_done) begin
        got_cpu = cpu_done;
        got_dma = dma_done;
        return;
      end
    end
    chk("done_timeout", 64'd1, 64'd0);
  endtask

  logic gc, gd;
  logic exp_dma;

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = '0;
    mem[9'h005] = 32'hDEADBEEF;
    reset = 1'b0;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
    #23;
    chk("rst_read",  64'(ram_read),  64'd0);
    chk("rst_write", 64'(ram_write), 64'd0);
    chk("rst_busy",  64'(busy),      64'd0);
    chk("rst_grant", 64'(grant_dma), 64'd0);
    chk("rst_done",  64'({cpu_done, dma_done}), 64'd0);
    chk("rst_addr",  64'(ram_addr),  64'd0);
    chk("rst_rdata", 64'({cpu_rdata, dma_rdata}), 64'd0);
    reset = 1'b1;
    tick();

    // CPU read of 0x05, cycle-accurate
    cpu_req = 1; cpu_we = 0; cpu_addr = 9'h005;
    tick();
    chk("rd_c1_read", 64'(ram_read),  64'd1);
    chk("rd_c1_wr",   64'(ram_write), 64'd0);
    chk("rd_c1_addr", 64'(ram_addr),  64'h005);
    chk("rd_c1_busy", 64'(busy),      64'd1);
    chk("rd_c1_gnt",  64'(grant_dma), 64'd0);
    chk("rd_c1_done", 64'(cpu_done),  64'd0);
    tick();
    chk("rd_c2_read", 64'(ram_read),  64'd1);
    chk("rd_c2_done", 64'(cpu_done),  64'd0);
    tick();
    chk("rd_c3_read", 64'(ram_read),  64'd0);
    chk("rd_c3_done", 64'(cpu_done),  64'd1);
    chk("rd_c3_data", 64'(cpu_rdata), 64'hDEADBEEF);
    chk("rd_c3_dmad", 64'(dma_rdata), 64'd0);
    cpu_req = 0;
    tick();
    chk("rd_c4_done", 64'(cpu_done),  64'd0);

    // DMA write 0x12345678 -> 0x1FF
    dma_req = 1; dma_we = 1; dma_addr = 9'h1FF; dma_wdata = 32'h12345678;
    tick();
    chk("wr_c1_write", 64'(ram_write), 64'd1);
    chk("wr_c1_read",  64'(ram_read),  64'd0);
    chk("wr_c1_addr",  64'(ram_addr),  64'h1FF);
    chk("wr_c1_gnt",   64'(grant_dma), 64'd1);
    tick();
    chk("wr_c2_write", 64'(ram_write), 64'd1);
    tick();
    chk("wr_c3_write", 64'(ram_write), 64'd0);
    chk("wr_c3_done",  64'(dma_done),  64'd1);
    chk("wr_c3_rdata", 64'(dma_rdata), 64'd0);
    chk("wr_mem",      64'(mem[9'h1FF]), 64'h12345678);
    dma_req = 0; dma_we = 0;
    tick();

    cpu_req = 1; cpu_we = 0; cpu_addr = 9'h1FF;
    wait_done(gc, gd);
    chk("rb_owner", 64'({gc, gd}), 64'b10);
    chk("rb_data",  64'(cpu_rdata), 64'h12345678);
    cpu_req = 0;
    tick();

    // Inputs changing mid-access are ignored
    cpu_req = 1; cpu_we = 0; cpu_addr = 9'h005;
    tick();
    cpu_we = 1; cpu_addr = 9'h010; cpu_wdata = 32'hCAFEF00D;
    tick();
    chk("chg_addr",  64'(ram_addr),  64'h005);
    chk("chg_read",  64'(ram_read),  64'd1);
    chk("chg_write", 64'(ram_write), 64'd0);
    tick();
    chk("chg_done",  64'(cpu_done),  64'd1);
    chk("chg_data",  64'(cpu_rdata), 64'hDEADBEEF);
    chk("chg_mem",   64'(mem[9'h010]), 64'd0);
    cpu_req = 0; cpu_we = 0;
    tick();

    // Reset mid-access: strobe drops without a clock edge, no done pulse
    cpu_req = 1; cpu_addr = 9'h005;
    tick();
    chk("mrst_pre", 64'(ram_read), 64'd1);
    #2 reset = 1'b0;
    #1;
    chk("mrst_read", 64'(ram_read), 64'd0);
    chk("mrst_busy", 64'(busy),     64'd0);
    tick();
    tick();
    chk("mrst_done", 64'(cpu_done), 64'd0);
    #3 reset = 1'b1;
    tick();
    chk("mrst_regrant", 64'(ram_read), 64'd1);
    wait_done(gc, gd);
    chk("mrst_owner", 64'({gc, gd}), 64'b10);
    cpu_req = 0;
    tick();

    // Tie arbitration from a fresh reset, both requests held
    reset = 1'b0;
    cpu_req = 1; cpu_we = 0; cpu_addr = 9'h005;
    dma_req = 1; dma_we = 0; dma_addr = 9'h1FF;
    #4 reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
`ifdef RAM_ARB_CPU_PRIORITY_EN
      exp_dma = 1'b0;
`else
      exp_dma = k[0];
`endif
      wait_done(gc, gd);
      chk($sformatf("tie_owner%0d", k), 64'({gc, gd}), exp_dma ? 64'b01 : 64'b10);
      if (exp_dma) chk($sformatf("tie_data%0d", k), 64'(dma_rdata), 64'h12345678);
      else         chk($sformatf("tie_data%0d", k), 64'(cpu_rdata), 64'hDEADBEEF);
    end
    cpu_req = 0;
    wait_done(gc, gd);
    chk("tie_dma_last", 64'({gc, gd}), 64'b01);
    chk("tie_dma_data", 64'(dma_rdata), 64'h12345678);
    dma_req = 0;
    tick();
    tick();
    chk("idle_busy", 64'(busy), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
